// File: rtl/muldiv_defs.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// operand width, funct3 operation encodings and FSM state encodings.
package muldiv_defs;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps
// on a shared 64-bit shift register, fixed 33-cycle latency, one op in flight.
module muldiv_unit
    import muldiv_defs::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    state_t          state;
    state_t          next_state;
    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic [4:0]      count;
    logic [XLEN-1:0] opnd;
    logic [63:0]     acc;
    logic            neg_q;
    logic            neg_r;

    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [32:0]     add_sum;
    logic [32:0]     sub_diff;
    logic [63:0]     prod_fix;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fin_result;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (count == 5'd31) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand signedness per funct3; a negative signed operand is stored as its magnitude.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op)
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: begin
                a_signed = 1'b0;
                b_signed = 1'b0;
            end
        endcase
        a_neg = a_signed & rs1_data[XLEN-1];
        b_neg = b_signed & rs2_data[XLEN-1];
        a_mag = a_neg ? (~rs1_data + 32'd1) : rs1_data;
        b_mag = b_neg ? (~rs2_data + 32'd1) : rs2_data;
    end

    assign add_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
    assign sub_diff = acc[63:31] - {1'b0, opnd};

    // Signed overflow (-2^31 / -1) falls out of the magnitude datapath as
    // quotient 0x80000000 and remainder 0; only divide-by-zero needs an override.
    always_comb begin
        prod_fix   = neg_q ? (~acc + 64'd1) : acc;
        quot_fix   = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix    = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
        fin_result = '0;
        case (op_q)
            OP_MUL:                        fin_result = prod_fix[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin_result = prod_fix[63:32];
            OP_DIV, OP_DIVU:               fin_result = (opnd == '0) ? '1 : quot_fix;
            OP_REM, OP_REMU:               fin_result = rem_fix;
            default:                       fin_result = '0;
        endcase
    end

    // Multiply keeps the multiplicand in opnd and the multiplier in acc[31:0];
    // divide keeps the divisor in opnd and the dividend in acc[31:0].
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q   <= '0;
            rd_q   <= '0;
            count  <= '0;
            opnd   <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            rd_out <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        rd_q  <= rd_in;
                        count <= '0;
                        opnd  <= op[2] ? b_mag : a_mag;
                        acc   <= {32'd0, (op[2] ? a_mag : b_mag)};
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                    end
                end
                CALC: begin
                    count <= count + 5'd1;
                    if (op_q[2]) begin
                        if (!sub_diff[32]) begin
                            acc <= {sub_diff[31:0], acc[30:0], 1'b1};
                        end else begin
                            acc <= {acc[62:0], 1'b0};
                        end
                    end else begin
                        if (acc[0]) begin
                            acc <= {add_sum, acc[31:1]};
                        end else begin
                            acc <= {1'b0, acc[63:1]};
                        end
                    end
                end
                FINISH: begin
                    result <= fin_result;
                    rd_out <= rd_q;
                    done   <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of RV32M vectors through a
// result scoreboard, plus issue-rule, back-to-back and mid-operation reset sequences.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks;
    int   errors;

    muldiv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if a wait logic bug hangs it.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Drives a request that is sampled by the next rising edge, then drops start.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] exp);
        exp_t e;
        op       = o;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        start    = 1'b1;
        e.res    = exp;
        e.rd     = rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        rs1_data = ~a;
        rs2_data = ~b;
        rd_in    = ~rd;
    endtask

    // Waits a bounded number of edges for done, checking latency, busy window and result.
    task automatic waitDone(input string name);
        int   lat;
        logic busy_ok;
        exp_t e;
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (k <= 32 && !busy) busy_ok = 1'b0;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got none required 1 entry", name);
        end else begin
            e = sb.pop_front();
            if (lat == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s timeout: got no done required done at edge 33", name);
            end else begin
                checkOutput({name, " latency"}, lat, 32'd33);
                checkOutput({name, " busy window"}, {31'd0, busy_ok}, 32'd1);
                checkOutput({name, " busy at done"}, {31'd0, busy}, 32'd0);
                checkOutput({name, " result"}, result, e.res);
                checkOutput({name, " rd_out"}, {27'd0, rd_out}, {27'd0, e.rd});
            end
        end
    endtask

    initial begin
        int   dones;
        int   lat;
        logic [31:0] seen_res;
        logic [4:0]  seen_rd;
        exp_t e;

        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        op       = 3'b000;
        rs1_data = '0;
        rs2_data = '0;
        rd_in    = '0;

        // {op, rs1, rs2, rd, expected result}
        vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF});
        vecs.push_back('{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'h0000_0001});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'h0000_0005, 5'd10, 32'hFFFF_FFFF});
        vecs.push_back('{3'b010, 32'h8000_0000, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFD});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd13, 32'hFFFF_FFFF});
        vecs.push_back('{3'b101, 32'h0000_0064, 32'h0000_0007, 5'd14, 32'h0000_000E});
        vecs.push_back('{3'b111, 32'h0000_0064, 32'h0000_0007, 5'd15, 32'h0000_0002});
        vecs.push_back('{3'b100, 32'h0000_0005, 32'h0000_0000, 5'd16, 32'hFFFF_FFFF});
        vecs.push_back('{3'b101, 32'h0000_0020, 32'h0000_0000, 5'd17, 32'hFFFF_FFFF});
        vecs.push_back('{3'b110, 32'h0000_0005, 32'h0000_0000, 5'd18, 32'h0000_0005});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 5'd19, 32'hFFFF_FFFF});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 5'd20, 32'hFFFF_FFF9});
        vecs.push_back('{3'b111, 32'hDEAD_BEEF, 32'h0000_0000, 5'd21, 32'hDEAD_BEEF});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h0000_0000});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'h0000_0010, 5'd24, 32'h0FFF_FFFF});

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset rd_out", {27'd0, rd_out}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] table vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);
            waitDone($sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d done width", i), {31'd0, done}, 32'd0);
        end

        $display("[TB] start while busy is ignored");
        applyStimulus(3'b000, 32'd3, 32'd4, 5'd9, 32'h0000_000C);
        dones    = 0;
        lat      = 0;
        seen_res = '0;
        seen_rd  = '0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5 || k == 20) begin
                op       = 3'b100;
                rs1_data = 32'd9;
                rs2_data = 32'd3;
                rd_in    = 5'd30;
                start    = 1'b1;
            end else begin
                start    = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    lat      = k;
                    seen_res = result;
                    seen_rd  = rd_out;
                end
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        checkOutput("ignored done count", dones, 32'd1);
        checkOutput("ignored latency", lat, 32'd33);
        checkOutput("ignored result", seen_res, e.res);
        checkOutput("ignored rd_out", {27'd0, seen_rd}, {27'd0, e.rd});

        $display("[TB] back-to-back issue in the done cycle");
        applyStimulus(3'b101, 32'd100, 32'd7, 5'd3, 32'h0000_000E);
        waitDone("b2b first");
        applyStimulus(3'b101, 32'd9, 32'd3, 5'd4, 32'h0000_0003);
        checkOutput("b2b done width", {31'd0, done}, 32'd0);
        checkOutput("b2b result held", result, 32'h0000_000E);
        waitDone("b2b second");

        $display("[TB] reset mid-operation");
        applyStimulus(3'b101, 32'd1000, 32'd7, 5'd12, 32'd142);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        checkOutput("midreset busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset done", {31'd0, done}, 32'd0);
        checkOutput("midreset result", result, 32'd0);
        checkOutput("midreset rd_out", {27'd0, rd_out}, 32'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checkOutput("midreset no done", dones, 32'd0);
        applyStimulus(3'b111, 32'd1000, 32'd7, 5'd25, 32'd6);
        waitDone("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
